// File: rtl/elastic_stream_buffer.sv
// Elastic FIFO buffer for valid/ready streams: registered head word plus a DEPTH-1 entry ring.
// One cycle insert-to-output latency; input_ready comes from registered level only (bubble after full).
module elastic_stream_buffer #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       input_valid,
  output logic                       input_ready,
  input  logic [WIDTH-1:0]           input_data,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic [WIDTH-1:0]           output_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);

  localparam int LW   = $clog2(DEPTH + 1);
  localparam int RING = DEPTH - 1;
  localparam int PW   = (RING > 1) ? $clog2(RING) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(RING - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             af_q, af_d;
  logic [WIDTH-1:0] ring_q [RING];
  logic [WIDTH-1:0] ring_d [RING];

  logic in_rdy;
  logic insert;
  logic remove;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy       = !rst && (level_q != LVL_FULL);
  assign input_ready  = in_rdy;
  assign output_valid = (level_q != '0);
  assign output_data  = head_q;
  assign level        = level_q;
  assign almost_full  = af_q;

  assign insert = input_valid && in_rdy;
  assign remove = output_valid && output_ready;

  always_comb begin
    level_d  = level_q;
    head_d   = head_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ring_d   = ring_q;

    if (flush) begin
      // Frame abort: drop everything, including a word offered this cycle.
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      level_d = level_q + {{(LW-1){1'b0}}, insert} - {{(LW-1){1'b0}}, remove};

      if (level_q == '0) begin
        if (insert) begin
          head_d = input_data;
        end
      end else if (remove) begin
        if (level_q == LVL_ONE) begin
          if (insert) begin
            head_d = input_data;
          end
        end else begin
          head_d   = ring_q[rd_ptr_q];
          rd_ptr_d = ptr_inc(rd_ptr_q);
          if (insert) begin
            ring_d[wr_ptr_q] = input_data;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
          end
        end
      end else if (insert) begin
        ring_d[wr_ptr_q] = input_data;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
    end

    af_d = (level_d >= LVL_AF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      af_q     <= 1'b0;
      for (int i = 0; i < RING; i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      level_q  <= level_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      af_q     <= af_d;
      ring_q   <= ring_d;
    end
  end

endmodule

// File: tb/tb_elastic_stream_buffer.sv
// Randomised and directed bench for elastic_stream_buffer against a queue reference model.
module tb_elastic_stream_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             input_valid = 1'b0;
  logic             input_ready;
  logic [WIDTH-1:0] input_data = '0;
  logic             output_valid;
  logic             output_ready = 1'b0;
  logic [WIDTH-1:0] output_data;
  logic [2:0]       level;
  logic             almost_full;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];

  elastic_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Advance one clock and apply the behavioural rules to the reference queue.
  task automatic tick();
    bit ins, rem;
    logic [WIDTH-1:0] d;
    ins = input_valid && !rst && (mq.size() != DEPTH);
    rem = (mq.size() != 0) && output_ready;
    d   = input_data;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (rem) void'(mq.pop_front());
      if (ins) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (input_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_rdy got=%b exp=0", input_ready);
    end
    tick();
    checks++;
    if (level !== 3'd0 || output_valid !== 1'b0 || output_data !== 8'h00 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got lvl=%0d vld=%b dat=%h af=%b exp 0/0/00/0",
               level, output_valid, output_data, almost_full);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (input_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_rdy got=%b exp=1", input_ready);
    end
  endtask

  task automatic test_single();
    output_ready = 1'b1;
    input_valid  = 1'b1;
    input_data   = 8'h11;
    tick();
    input_valid = 1'b0;
    checks++;
    if (output_valid !== 1'b1 || output_data !== 8'h11 || level !== 3'd1) begin
      errors++;
      $display("FAIL single_out got vld=%b dat=%h lvl=%0d exp 1/11/1", output_valid, output_data, level);
    end
    tick();
    checks++;
    if (output_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL single_drain got vld=%b lvl=%0d exp 0/0", output_valid, level);
    end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] got[$];
    int exp_lvl;
    output_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      input_valid = 1'b1;
      input_data  = 8'(i);
      tick();
      exp_lvl = (i < DEPTH) ? i : DEPTH;
      checks++;
      if (level !== 3'(exp_lvl) || almost_full !== (exp_lvl >= AF)) begin
        errors++;
        $display("FAIL fill_level step=%0d got lvl=%0d af=%b exp lvl=%0d af=%b",
                 i, level, almost_full, exp_lvl, exp_lvl >= AF);
      end
      if (i >= 4) begin
        checks++;
        if (input_ready !== 1'b0) begin
          errors++; $display("FAIL fill_full_rdy step=%0d got=%b exp=0", i, input_ready);
        end
      end
    end
    input_valid  = 1'b1;
    input_data   = 8'h05;
    output_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      bit took;
      if (output_valid && output_ready) got.push_back(output_data);
      took = input_valid && input_ready;
      tick();
      if (took) input_valid = 1'b0;
    end
    input_valid = 1'b0;
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL fill_drain_count got=%0d exp=5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== 8'(k + 1)) begin
          errors++; $display("FAIL fill_order idx=%0d got=%h exp=%h", k, got[k], 8'(k + 1));
        end
      end
    end
    while (mq.size() != 0) tick();
  endtask

  task automatic test_flow();
    output_ready = 1'b1;
    input_valid  = 1'b1;
    input_data   = 8'h20;
    tick();
    for (int i = 1; i <= 8; i++) begin
      input_data = 8'(8'h20 + i);
      checks++;
      if (output_valid !== 1'b1 || output_data !== 8'(8'h20 + i - 1) || level !== 3'd1) begin
        errors++;
        $display("FAIL flow step=%0d got vld=%b dat=%h lvl=%0d exp 1/%h/1",
                 i, output_valid, output_data, level, 8'(8'h20 + i - 1));
      end
      tick();
    end
    input_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit prev_stall = 0;
    logic [WIDTH-1:0] prev_dat = '0;
    for (int c = 0; c < 10000; c++) begin
      input_valid  = ($urandom_range(0, 9) < 6);
      output_ready = ($urandom_range(0, 9) < 5);
      input_data   = 8'($urandom);
      flush        = ($urandom_range(0, 299) == 0);
      #1;
      checks++;
      if (level !== 3'(mq.size()) || output_valid !== (mq.size() != 0) ||
          almost_full !== (mq.size() >= AF) || input_ready !== (mq.size() != DEPTH)) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got lvl=%0d vld=%b af=%b rdy=%b exp lvl=%0d",
                 c, level, output_valid, almost_full, input_ready, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (output_data !== mq[0]) begin
          errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, output_data, mq[0]);
        end
      end
      if (prev_stall) begin
        checks++;
        if (output_data !== prev_dat || output_valid !== 1'b1) begin
          errors++;
          $display("FAIL rand_stall cyc=%0d got dat=%h vld=%b exp dat=%h vld=1",
                   c, output_data, output_valid, prev_dat);
        end
      end
      prev_stall = output_valid && !output_ready && !flush;
      prev_dat   = output_data;
      tick();
    end
    flush        = 1'b0;
    input_valid  = 1'b0;
    output_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_flush();
    output_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      input_valid = 1'b1;
      input_data  = 8'(8'h31 + i);
      tick();
    end
    checks++;
    if (level !== 3'd3) begin
      errors++; $display("FAIL flush_pre_level got=%0d exp=3", level);
    end
    flush       = 1'b1;
    input_data  = 8'hAA;
    tick();
    flush       = 1'b0;
    input_valid = 1'b0;
    checks++;
    if (level !== 3'd0 || output_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got lvl=%0d vld=%b exp 0/0", level, output_valid);
    end
    output_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (output_valid !== 1'b0) begin
        errors++; $display("FAIL flush_ghost cyc=%0d got vld=%b dat=%h exp vld=0", c, output_valid, output_data);
      end
    end
  endtask

  task automatic test_rst_mid();
    output_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      input_valid = 1'b1;
      input_data  = 8'(8'h41 + i);
      tick();
    end
    input_valid = 1'b0;
    checks++;
    if (level !== 3'd2) begin
      errors++; $display("FAIL rstmid_pre_level got=%0d exp=2", level);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (input_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_rdy got=%b exp=0", input_ready);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (level !== 3'd0 || output_valid !== 1'b0 || output_data !== 8'h00 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state got lvl=%0d vld=%b dat=%h af=%b exp 0/0/00/0",
               level, output_valid, output_data, almost_full);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_flow();
    test_random();
    test_flush();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
